// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response FIFO, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN adds fetch_misalign and halts fetch on a misaligned redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  // Handshakes: a transfer occurs on a rising edge where valid & ready are both high;
  // valid never depends on ready, and the payload holds while valid & !ready.

  logic [31:0]   pc;
  logic [CW-1:0] out_cnt, drop_cnt, fifo_cnt, out_next, live_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [CW:0]   used;
  logic [31:0]   rsp_pc, target_pc;
  logic          req_fire, rsp_keep, push, pop, halted;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign halted         = misalign_q;
  assign fetch_misalign = misalign_q;
  assign target_pc      = redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        misalign_q <= 1'b0;
    else if (redirect) misalign_q <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign halted    = 1'b0;
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    // Credits count every in-flight request, including ones that will be dropped.
    used           = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    imem_req_valid = rst_n && !redirect && !halted && (used < {1'b0, DEPTH_C});
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    instr_valid    = (fifo_cnt != '0);
    instr          = buf_data[rd_ptr];
    instr_pc       = buf_pc[rd_ptr];
    pop            = instr_valid && instr_ready;
    rsp_keep       = imem_rsp_valid && !redirect && (drop_cnt == '0);
    push           = rsp_keep && ((fifo_cnt != DEPTH_C) || pop);
    // Live requests are contiguous and end just below pc.
    live_cnt       = out_cnt - drop_cnt;
    rsp_pc         = pc - {{(30 - CW){1'b0}}, live_cnt, 2'b00};
    out_next       = out_cnt;
    if (req_fire && !imem_rsp_valid && (out_cnt != DEPTH_C))
      out_next = out_cnt + CW'(1);
    else if (!req_fire && imem_rsp_valid && (out_cnt != '0))
      out_next = out_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      out_cnt <= out_next;
      if (redirect) begin
        pc       <= target_pc;
        drop_cnt <= out_next;
        fifo_cnt <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          buf_data[wr_ptr] <= imem_rsp_data;
          buf_pc[wr_ptr]   <= rsp_pc;
          wr_ptr           <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
        else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic checked against
// an accepted-request queue model and a variable-latency in-order memory.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  instr_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] p);
`ifdef FETCH_MISALIGN_TRAP_EN
    return p;
`else
    return p & 32'hFFFF_FFFC;
`endif
  endfunction

  // memory model: in-order, latency per request, never back-pressured
  logic [31:0] mem_q[$];
  int          mem_due[$];
  int          mem_lat = 1;
  bit          rand_lat = 0;
  int          last_due = 0;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (rst_n && mem_q.size() > 0 && mem_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q.pop_front());
        void'(mem_due.pop_front());
      end
    end
  end

  // scoreboard: exp_q holds accepted, not-yet-consumed fetch addresses in order
  logic [31:0] exp_q[$];
  logic [31:0] exp_req, prev_addr, prev_instr, prev_pc, p;
  bit          prev_stall, prev_hold;
  int          sz, lat, due;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); mem_q.delete(); mem_due.delete();
      last_due = 0; exp_req = RESET_PC; prev_stall = 0; prev_hold = 0;
    end else begin
      if (prev_stall && !redirect) begin
        check("req_hold_valid", 32'(imem_req_valid), 32'd1);
        check("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (prev_hold) begin
        check("instr_hold_valid", 32'(instr_valid), 32'd1);
        check("instr_hold_word", instr, prev_instr);
        check("instr_hold_pc", instr_pc, prev_pc);
      end
      if (redirect) begin
        exp_q.delete();
        exp_req = target_of(redirect_pc);
        check("redir_no_req", 32'(imem_req_valid), 32'd0);
      end else begin
        sz = exp_q.size();
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) check("pop_unexpected", 32'(exp_q.size()), 32'd1);
          else begin
            p = exp_q.pop_front();
            check("pop_pc", instr_pc, p);
            check("pop_word", instr, mem_word(p));
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_req);
          check("req_credit", 32'(sz < BUF_DEPTH), 32'd1);
          exp_q.push_back(imem_req_addr);
          exp_req = exp_req + 32'd4;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        mem_q.push_back(imem_req_addr);
        mem_due.push_back(due);
        last_due = due;
      end
      prev_stall = imem_req_valid && !imem_req_ready && !redirect;
      prev_addr  = imem_req_addr;
      prev_hold  = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] t, input logic rdy);
    tick();
    redirect = 1'b1; redirect_pc = t; instr_ready = rdy;
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    step();
    check("redir_flush", 32'(instr_valid), 32'd0);
  endtask

  task automatic wait_pop_pc(input logic [31:0] exp_pc, input string tag);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (instr_valid && instr_ready) begin
        check(tag, instr_pc, exp_pc);
        found = 1;
      end
    end
    if (!found) check({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");

    // reset release with a 1-cycle memory
    tick(); rst_n = 1'b1;
    step();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
    check("first_iv_c0", 32'(instr_valid), 32'd0);
    step();
    check("first_iv_c1", 32'(instr_valid), 32'd0);
    check("second_req_addr", imem_req_addr, RESET_PC + 32'd4);
    step();
    check("first_iv_c2", 32'(instr_valid), 32'd1);
    check("first_instr_pc", instr_pc, RESET_PC);
    wait_pop_pc(RESET_PC + 32'd4, "seq_pc4");
    wait_pop_pc(RESET_PC + 32'd8, "seq_pc8");

    // decode stall: buffer fills to BUF_DEPTH then requests stop
    tick(); instr_ready = 1'b0;
    repeat (10) tick();
    step();
    check("stall_credit", 32'(exp_q.size()), 32'(BUF_DEPTH));
    check("stall_no_req", 32'(imem_req_valid), 32'd0);
    check("stall_head_pc", instr_pc, exp_q[0]);
    tick(); instr_ready = 1'b1;

    // redirect with responses in flight
    mem_lat = 3;
    repeat (8) tick();
    do_redirect(32'h0000_0100, 1'b1);
    wait_pop_pc(32'h0000_0100, "redir_inflight_pc");
    wait_pop_pc(32'h0000_0104, "redir_inflight_next");

    // redirect coincident with a pop from a full buffer
    mem_lat = 1;
    tick(); instr_ready = 1'b0;
    repeat (8) tick();
    step();
    check("full_before_redir", 32'(exp_q.size()), 32'(BUF_DEPTH));
    do_redirect(32'h0000_0100, 1'b1);
    wait_pop_pc(32'h0000_0100, "redir_full_pc");
    wait_pop_pc(32'h0000_0104, "redir_full_next");

`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h0000_0102, 1'b1);
    check("misalign_set", 32'(fetch_misalign), 32'd1);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req_valid) quiet++;
    end
    check("misalign_no_req", 32'(quiet), 32'd0);
    do_redirect(32'h0000_0200, 1'b1);
    check("misalign_clear", 32'(fetch_misalign), 32'd0);
    wait_pop_pc(32'h0000_0200, "misalign_resume");
`else
    quiet = 0;
    do_redirect(32'h0000_010A, 1'b1);
    wait_pop_pc(32'h0000_0108, "redir_align");
`endif

    // randomized traffic with occasional redirects
    rand_lat = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        redirect = 1'b1; redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      end else begin
        redirect = 1'b0;
      end
    end
    tick(); redirect = 1'b0;

    // reset in the middle of traffic
    repeat (5) tick();
    #2 rst_n = 1'b0;
    step();
    check_reset_outputs("midreset");
    rand_lat = 0; mem_lat = 1;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_pop_pc(RESET_PC, "post_reset_pc0");
    wait_pop_pc(RESET_PC + 32'd4, "post_reset_pc4");

    repeat (10) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries, legal values 2 or 4.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_req_addr  output  32  word address of the fetch.
REQ-008 SHALL have port imem_rsp_valid  input  1  response valid; in-order, never back-pressured.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port instr_valid  output  1  instruction available to decode/extend.
REQ-011 SHALL have port instr_ready  input  1  decode consumes the instruction.
REQ-012 SHALL have port instr  output  32  instruction word; bits [31:7] drive the immediate extender.
REQ-013 SHALL have port instr_pc  output  32  PC of instr.
REQ-014 SHALL have port redirect  input  1  branch/jal taken; flush and refetch.
REQ-015 SHALL have port redirect_pc  input  32  new PC (pc + imm_ext from the extender).

Function
REQ-016 SHALL hold fetch PC; each accepted request (valid&ready) advances PC by 4.
REQ-017 SHALL assert imem_req_valid only when outstanding + buffer occupancy < BUF_DEPTH, so every response has a free slot.
REQ-018 SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-019 SHALL write each non-discarded response into a FIFO of BUF_DEPTH entries with its PC; wrap-around of read/write pointers SHALL be modulo BUF_DEPTH.
REQ-020 SHALL present the FIFO head on instr/instr_pc with instr_valid=1 when non-empty; pop on instr_valid&instr_ready.
REQ-021 SHALL hold instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-022 SHALL have minimum latency of one cycle from imem_rsp_valid to instr_valid (registered buffer, no bypass).
REQ-023 SHALL, on redirect=1: empty the FIFO, load PC with redirect_pc, set drop counter to the number of outstanding requests (including one accepted that same cycle); instr_valid=0 next cycle.
REQ-024 SHALL discard responses while drop counter > 0, decrementing per response; a response coincident with redirect counts as pre-redirect and is discarded.
REQ-025 SHALL give redirect priority over pop, push, and PC increment in the same cycle; no request issued in the redirect cycle.
REQ-026 SHALL allow simultaneous push and pop with the FIFO full (occupancy unchanged).
REQ-027 SHALL keep the outstanding counter saturated at BUF_DEPTH; no overflow or underflow.

Reset
REQ-028 SHALL on rst_n=0 asynchronously set: PC=RESET_PC, FIFO empty, outstanding=0, drop=0, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-029 SHALL issue first request to RESET_PC in the first cycle after rst_n deasserts.
REQ-030 SHALL abandon in-flight responses on reset mid-operation; the bench SHALL treat memory as reset too.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_TRAP_EN defined, add output fetch_misalign (1 bit): set when redirect_pc[1:0]!=0, fetching halted (imem_req_valid=0) until next redirect or reset.
REQ-032 SHALL, without FETCH_MISALIGN_TRAP_EN, omit fetch_misalign and force redirect_pc[1:0] to 2'b00.

Verification
REQ-033 SHALL cover: reset release, imem_req_ready=1, 1-cycle memory -> addresses 0x0,0x4,0x8; instr_pc matches, instr_valid first high 2 cycles after first request.
REQ-034 SHALL cover: instr_ready=0 for 10 cycles -> exactly BUF_DEPTH requests outstanding/buffered, then imem_req_valid=0, instr held stable.
REQ-035 SHALL cover: redirect to 0x100 with 2 responses in flight -> both discarded, next instr_pc=0x100.
REQ-036 SHALL cover: redirect and full-FIFO pop in same cycle -> FIFO empty, no instruction lost or duplicated after 0x100.
REQ-037 SHALL cover: imem_req_ready random 50% -> addr stable during stall, PC sequence contiguous.
REQ-038 SHALL cover (FETCH_MISALIGN_TRAP_EN): redirect_pc=0x102 -> fetch_misalign=1, no requests until redirect to 0x200.
